// File: rtl/adc_pkg.sv
// Shared types and helpers for the serial ADC sampler.
package adc_pkg;

    localparam int unsigned ADC_BITS = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } adc_state_e;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI clock generator (CPOL=0): CLK_DIV clkin cycles per phase while enabled,
// with a strike on the last cycle of each high phase where the master samples miso.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic sample_c
);

    localparam int unsigned CNT_W = (clog2(CLK_DIV) > 0) ? clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_end_c;

    assign phase_end_c = en && (cnt_q == CNT_LAST);
    assign sample_c    = phase_end_c && sclk;

    // Disabled generator parks low with a cleared counter, so each frame starts with a full low phase.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (phase_end_c) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Serial ADC read master with analog-mux channel select, single-shot and continuous modes.
// Optional ADC_SCAN_EN: continuous mode steps the channel through 0..CHANNELS-1 after each frame.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int unsigned  DATA_BITS = ADC_BITS,
    parameter int unsigned  CLK_DIV   = 1,
    parameter int unsigned  CS_SETUP  = 1,
    parameter int unsigned  CS_GAP    = 2,
    parameter int unsigned  CHANNELS  = 4,
    localparam int unsigned CH_BITS   = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 cont,
    input  logic [CH_BITS-1:0]   ch_sel,
    output logic                 busy,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data_o,
    output logic [CH_BITS-1:0]   data_ch,
    output logic [CH_BITS-1:0]   mux_sel,
    output logic                 sclk,
    input  logic                 miso,
    output logic                 cs
);

    localparam int unsigned TMR_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);
    localparam int unsigned BC_W    = clog2(DATA_BITS + 1);

    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);
    localparam logic [BC_W-1:0]  BC_INIT    = BC_W'(DATA_BITS);

    adc_state_e           state_q, state_d;
    logic                 cs_d, busy_d, valid_d;
    logic [DATA_BITS-1:0] data_d, sh_q, sh_d, shift_c;
    logic [CH_BITS-1:0]   dch_d, mux_d, rearm_ch_c;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic                 sample_c;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .en       (state_q == ST_SHIFT),
        .sclk     (sclk),
        .sample_c (sample_c)
    );

    assign shift_c = {sh_q[DATA_BITS-2:0], miso};

    // Channel for a back-to-back continuous frame; mux_sel doubles as the scan pointer.
`ifdef ADC_SCAN_EN
    assign rearm_ch_c = (mux_sel == CH_BITS'(CHANNELS - 1)) ? '0 : mux_sel + CH_BITS'(1);
`else
    assign rearm_ch_c = ch_sel;
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cs      <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b0;
            data_o  <= '0;
            data_ch <= '0;
            mux_sel <= '0;
            sh_q    <= '0;
            tmr_q   <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            cs      <= cs_d;
            busy    <= busy_d;
            valid   <= valid_d;
            data_o  <= data_d;
            data_ch <= dch_d;
            mux_sel <= mux_d;
            sh_q    <= sh_d;
            tmr_q   <= tmr_d;
            bc_q    <= bc_d;
        end
    end

    // Next state plus next values of every registered output; valid is high only in DONE.
    always_comb begin
        state_d = state_q;
        cs_d    = cs;
        busy_d  = busy;
        valid_d = 1'b0;
        data_d  = data_o;
        dch_d   = data_ch;
        mux_d   = mux_sel;
        sh_d    = sh_q;
        tmr_d   = tmr_q;
        bc_d    = bc_q;
        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (go || cont) begin
                    mux_d   = ch_sel;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    sh_d    = '0;
                    tmr_d   = '0;
                    bc_d    = BC_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETUP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sample_c) begin
                    sh_d = shift_c;
                    bc_d = bc_q - BC_W'(1);
                    if (bc_q == BC_W'(1)) begin
                        data_d  = shift_c;
                        dch_d   = mux_sel;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cs_d    = 1'b1;
                tmr_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (cont) begin
                        mux_d   = rearm_ch_c;
                        cs_d    = 1'b0;
                        sh_d    = '0;
                        bc_d    = BC_INIT;
                        state_d = ST_SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: u0 is the 14-bit/CLK_DIV=1/4-channel build,
// u1 the 8-bit/CLK_DIV=3/3-channel build; each has an ADC model driving miso after SCLK rises.
`timescale 1ns/1ps
module tb_adc_sampler;

    logic        clkin = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          fails = 0;

    logic        go0, cont0, miso0, busy0, valid0, sclk0, cs0;
    logic [1:0]  ch_sel0, dch0, mux0;
    logic [13:0] data0;
    logic [31:0] word0;

    logic        go1, cont1, miso1, busy1, valid1, sclk1, cs1;
    logic [1:0]  ch_sel1, dch1, mux1;
    logic [7:0]  data1;
    logic [31:0] word1;

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    adc_sampler #(
        .DATA_BITS (14), .CLK_DIV (1), .CS_SETUP (1), .CS_GAP (2), .CHANNELS (4)
    ) u0 (
        .clkin (clkin), .rst_n (rst_n), .go (go0), .cont (cont0), .ch_sel (ch_sel0),
        .busy (busy0), .valid (valid0), .data_o (data0), .data_ch (dch0),
        .mux_sel (mux0), .sclk (sclk0), .miso (miso0), .cs (cs0)
    );

    adc_sampler #(
        .DATA_BITS (8), .CLK_DIV (3), .CS_SETUP (1), .CS_GAP (2), .CHANNELS (3)
    ) u1 (
        .clkin (clkin), .rst_n (rst_n), .go (go1), .cont (cont1), .ch_sel (ch_sel1),
        .busy (busy1), .valid (valid1), .data_o (data1), .data_ch (dch1),
        .mux_sel (mux1), .sclk (sclk1), .miso (miso1), .cs (cs1)
    );

    // ADC models: garbage before the first rise, then bit k appears just after each SCLK rise.
    initial begin : adc0
        int k;
        miso0 = 1'b0;
        forever begin
            @(negedge cs0);
            #1;
            k = 14;
            miso0 = ~word0[13];
            while (k > 0) begin
                @(posedge sclk0 or posedge cs0);
                #1;
                if (cs0) break;
                k--;
                miso0 = word0[k];
            end
        end
    end

    initial begin : adc1
        int k;
        miso1 = 1'b0;
        forever begin
            @(negedge cs1);
            #1;
            k = 8;
            miso1 = ~word1[7];
            while (k > 0) begin
                @(posedge sclk1 or posedge cs1);
                #1;
                if (cs1) break;
                k--;
                miso1 = word1[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clkin);
            if ((which ? valid1 : valid0) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input bit which, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clkin);
            if ((which ? busy1 : busy0) === 1'b0) break;
        end
    endtask

    initial begin : main
        int t0, tv, t2, rises, falls, nv, bad, run, gaps;
        logic prev, seen, changed;
        logic [1:0] chs [4];
        logic [7:0] dat [4];
        logic [1:0] exp_ch [4];

        rst_n = 1'b0;
        go0 = 1'b0; cont0 = 1'b0; ch_sel0 = 2'd0; word0 = '0;
        go1 = 1'b0; cont1 = 1'b0; ch_sel1 = 2'd0; word1 = '0;
        repeat (3) @(negedge clkin);
        chk("rst_cs", 32'(cs0), 1);
        chk("rst_sclk", 32'(sclk0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_data", 32'(data0), 0);
        chk("rst_data_ch", 32'(dch0), 0);
        chk("rst_mux", 32'(mux0), 0);
        rst_n = 1'b1;

        // Single shot, 14 bits, channel 2, go at cycle 10.
        while (cyc < 10) @(negedge clkin);
        go0 = 1'b1; ch_sel0 = 2'd2; word0 = 'h2A5C;
        @(negedge clkin);
        go0 = 1'b0;
        prev = sclk0; rises = 0; tv = -1;
        for (int i = 0; i < 60; i++) begin
            if (sclk0 && !prev) rises++;
            prev = sclk0;
            if (valid0) begin
                tv = cyc;
                break;
            end
            @(negedge clkin);
        end
        chk("t1_valid_cycle", tv, 40);
        chk("t1_data", 32'(data0), 'h2A5C);
        chk("t1_data_ch", 32'(dch0), 2);
        chk("t1_mux", 32'(mux0), 2);
        chk("t1_sclk_rises", rises, 14);
        chk("t1_cs_low_in_done", 32'(cs0), 0);
        @(negedge clkin);
        chk("t1_cs_high_after", 32'(cs0), 1);
        chk("t1_valid_one_cycle", 32'(valid0), 0);
        wait_idle(0, 20);

        // go held high: a new frame starts in the first IDLE cycle after GAP.
        go0 = 1'b1; ch_sel0 = 2'd1; word0 = 'h155A;
        wait_valid(0, 60, tv);
        chk("t1b_data_first", 32'(data0), 'h155A);
        wait_valid(0, 60, t2);
        go0 = 1'b0;
        chk("t1b_period", t2 - tv, 33);
        chk("t1b_data_second", 32'(data0), 'h155A);
        chk("t1b_data_ch", 32'(dch0), 1);
        wait_idle(0, 20);

        // 8 bits at CLK_DIV=3: phase lengths, sample point and latency.
        go1 = 1'b1; ch_sel1 = 2'd1; word1 = 'h81; t0 = cyc;
        @(negedge clkin);
        go1 = 1'b0;
        prev = 1'b0; run = 0; bad = 0; rises = 0; seen = 1'b0; tv = -1;
        for (int i = 0; i < 100 && tv < 0; i++) begin
            @(negedge clkin);
            if (sclk1 != prev) begin
                if (prev) begin
                    if (run != 3) bad++;
                    seen = 1'b1;
                end else begin
                    rises++;
                    if (seen && run != 3) bad++;
                end
                run = 1;
            end else begin
                run++;
            end
            prev = sclk1;
            if (valid1) tv = cyc;
        end
        chk("t2_valid_cycle", tv, t0 + 50);
        chk("t2_phase_len_errors", bad, 0);
        chk("t2_sclk_rises", rises, 8);
        chk("t2_data", 32'(data1), 'h81);
        chk("t2_data_ch", 32'(dch1), 1);
        wait_idle(1, 20);

        // go and ch_sel toggled mid-SHIFT must neither restart nor retarget the frame.
        go0 = 1'b1; ch_sel0 = 2'd2; word0 = 'h1234;
        @(negedge clkin);
        go0 = 1'b0;
        chk("t3_data_held_on_start", 32'(data0), 'h155A);
        chk("t3_busy", 32'(busy0), 1);
        repeat (8) @(negedge clkin);
        go0 = 1'b1; ch_sel0 = 2'd3;
        repeat (2) @(negedge clkin);
        go0 = 1'b0;
        chk("t3_mux_stable", 32'(mux0), 2);
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clkin);
            if (valid0) nv++;
        end
        chk("t3_valid_count", nv, 1);
        chk("t3_data", 32'(data0), 'h1234);
        chk("t3_data_ch", 32'(dch0), 2);
        chk("t3_idle_busy", 32'(busy0), 0);
        chk("t3_idle_cs", 32'(cs0), 1);

        // Continuous mode from channel 1; ch_sel moves to 2 during the 2nd frame.
`ifdef ADC_SCAN_EN
        exp_ch[0] = 2'd1; exp_ch[1] = 2'd2; exp_ch[2] = 2'd0; exp_ch[3] = 2'd1;
`else
        exp_ch[0] = 2'd1; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd2;
`endif
        ch_sel1 = 2'd1; word1 = 'hA5; cont1 = 1'b1;
        nv = 0; run = 0; bad = 0; gaps = 0; changed = 1'b0;
        for (int i = 0; i < 400 && nv < 4; i++) begin
            @(negedge clkin);
            if (valid1) begin
                chs[nv] = dch1;
                dat[nv] = data1;
                nv++;
                if (nv == 4) cont1 = 1'b0;
            end
            if (cs1 && busy1) begin
                run++;
            end else if (!cs1 && run > 0) begin
                gaps++;
                if (run != 2) bad++;
                run = 0;
            end
            if (nv == 1 && gaps == 1 && !changed) begin
                ch_sel1 = 2'd2;
                changed = 1'b1;
            end
        end
        chk("t4_frames", nv, 4);
        chk("t4_gaps", gaps, 3);
        chk("t4_gap_len_errors", bad, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_ch%0d", i), 32'(chs[i]), 32'(exp_ch[i]));
            chk($sformatf("t4_data%0d", i), 32'(dat[i]), 'hA5);
        end
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clkin);
            if (valid1) nv++;
        end
        chk("t4_no_extra_frame", nv, 0);
        chk("t4_idle_busy", 32'(busy1), 0);

        // Reset after the 5th sampled bit, then a clean conversion.
        go0 = 1'b1; ch_sel0 = 2'd1; word0 = 'h3C5A;
        @(negedge clkin);
        go0 = 1'b0;
        prev = sclk0; falls = 0;
        for (int i = 0; i < 60 && falls < 5; i++) begin
            @(negedge clkin);
            if (prev && !sclk0) falls++;
            prev = sclk0;
        end
        chk("t5_reached_bit5", falls, 5);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cs", 32'(cs0), 1);
        chk("t5_rst_sclk", 32'(sclk0), 0);
        chk("t5_rst_busy", 32'(busy0), 0);
        chk("t5_rst_data", 32'(data0), 0);
        chk("t5_rst_data_ch", 32'(dch0), 0);
        chk("t5_rst_valid", 32'(valid0), 0);
        @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);
        go0 = 1'b1; ch_sel0 = 2'd3; word0 = 'h0F0F; t0 = cyc;
        @(negedge clkin);
        go0 = 1'b0;
        wait_valid(0, 60, tv);
        chk("t5_valid_cycle", tv, t0 + 30);
        chk("t5_data", 32'(data0), 'h0F0F);
        chk("t5_data_ch", 32'(dch0), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_sampler.md
Name: adc_sampler

Overview:
- Parametrised successor to the single-channel 14-bit ADC read block.
- Serial-ADC read master:
  - drives CS and SCLK (CPOL=0) and shifts DATA_BITS bits in MSB-first from MISO;
  - drives an external analog-mux channel select;
  - provides single-shot and continuous conversion modes, a programmable SCLK divider and CS setup/gap timing.
- Sits between the bus-pirate control logic and the on-board voltage-measurement ADC.
- Delivers a registered result plus a one-cycle valid strobe tagged with its channel.

Parameters:
- DATA_BITS, 14: bits per conversion (2..32).
- CLK_DIV, 1: clkin cycles per SCLK half-period (>=1); SCLK = clkin/(2*CLK_DIV).
- CS_SETUP, 1: clkin cycles from CS falling to first SCLK rise (>=1).
- CS_GAP, 2: minimum clkin cycles CS stays high between conversions (>=1).
- CHANNELS, 4: number of mux channels (>=1); CH_BITS = max(1, clog2(CHANNELS)).

Ports:
- clkin, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- go, input, 1: start request; sampled only in IDLE.
- cont, input, 1: continuous mode; re-arm after each gap while high.
- ch_sel, input, CH_BITS: requested channel, latched at start.
- busy, output, 1: high from accepted start until return to IDLE.
- valid, output, 1: one-cycle pulse when data_o/data_ch update.
- data_o, output, DATA_BITS: last completed conversion.
- data_ch, output, CH_BITS: channel of data_o.
- mux_sel, output, CH_BITS: analog mux select, stable while CS low.
- sclk, output, 1: SPI clock.
- miso, input, 1: ADC serial data.
- cs, output, 1: ADC chip select, active low.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: cs=1, sclk=0, busy=0, valid=0, data_o=0, data_ch=0, mux_sel=0.
  - Internal: FSM=IDLE, all counters 0.
  - Applies immediately mid-conversion; the partial result is discarded.
- FSM states: IDLE, SETTLE, SHIFT, DONE, GAP.
- IDLE:
  - cs=1, sclk=0, busy=0.
  - If go=1 or cont=1: mux_sel<=channel (ch_sel, or scan pointer with ADC_SCAN_EN), cs<=0, busy<=1, shift register cleared, SETTLE.
- SETTLE:
  - Count CS_SETUP cycles, then SHIFT.
  - SCLK still low.
- SHIFT:
  - Half-period counter runs CLK_DIV cycles per phase.
  - Low phase ends: sclk<=1.
  - High phase ends: sclk<=0 and miso is shifted into the register LSB (MSB-first overall); bit counter decrements.
  - After bit DATA_BITS is sampled: DONE.
- DONE (one cycle):
  - data_o<=shift register; data_ch<=mux_sel; valid=1.
  - cs<=1; GAP.
- GAP:
  - cs=1 for CS_GAP cycles.
  - Then, if cont=1: mux_sel updated, cs<=0, SETTLE directly (no IDLE cycle). Otherwise IDLE with busy<=0.
- Latency: go sampled at edge N -> valid high in cycle N+1+CS_SETUP+2*CLK_DIV*DATA_BITS.
- go while busy: ignored (no queueing).
- go held high in single-shot mode: a new conversion starts at the first IDLE cycle after GAP.
- cont dropped mid-conversion: current conversion completes with valid, then IDLE.
- ch_sel changes while busy: no effect until the next start.
- data_o/data_ch hold their value between valid pulses; they are never cleared by a start.

Optional Feature:
- Macro ADC_SCAN_EN.
- Defined:
  - In continuous mode the channel is taken from an internal scan pointer.
  - The pointer is loaded from ch_sel on the first start and incremented after each DONE, wrapping CHANNELS-1 -> 0 (non-power-of-two CHANNELS wraps correctly).
  - Single-shot mode uses ch_sel.
- Undefined: mux_sel always latches ch_sel at each start; no scan pointer logic.

Decomposition:
- Shared package (adc_pkg): FSM state encoding constants, clog2 function, ADC_BITS default constant.
- One natural sub-module, adc_sclk_gen: half-period counter producing sclk plus rise/sample strikes, parametrised by CLK_DIV. The FSM uses the sample strike to shift and to count bits.

Test Plan:
- Single-shot, CLK_DIV=1, DATA_BITS=14, ADC model returns 0x2A5C on ch 2, go pulse at cycle 10:
  - valid at cycle 10+1+1+28=40;
  - data_o=0x2A5C, data_ch=2;
  - exactly 14 SCLK rising edges, cs high from cycle 41.
- CLK_DIV=3, DATA_BITS=8, pattern 0x81:
  - SCLK high/low exactly 3 cycles each;
  - miso sampled at the end of each high phase;
  - data_o=0x81.
- go pulsed mid-SHIFT and ch_sel changed mid-SHIFT:
  - no restart, mux_sel unchanged;
  - a single valid pulse.
- cont=1 with ADC_SCAN_EN, CHANNELS=3, start ch 1:
  - data_ch sequence 1,2,0,1;
  - cs high exactly CS_GAP cycles between frames.
- cont=1 without ADC_SCAN_EN, ch_sel changed during the 2nd conversion: 3rd conversion uses the new channel.
- rst_n asserted mid-SHIFT (after bit 5):
  - cs=1, sclk=0, busy=0, data_o=0 immediately;
  - after release, a fresh go yields a correct full result.
